// File: rtl/ctrl_pipe_sequencer.sv
// Back-end control pipeline: carries the ID control bundle through
// NUM_STAGES stages with load-use interlock, forwarding selects, freeze
// and fetch-kill. Optional performance counters enabled by PERF_CNT_EN.
module ctrl_pipe_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int CTRL_W     = 8,
  parameter int REG_AW     = 3,
  parameter int FWD_W      = $clog2(NUM_STAGES + 1),
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         d_valid,
  input  logic [CTRL_W-1:0]            d_ctrl,
  input  logic                         d_regwr,
  input  logic                         d_memrd,
  input  logic [REG_AW-1:0]            d_rd,
  input  logic [REG_AW-1:0]            d_rs1,
  input  logic [REG_AW-1:0]            d_rs2,
  input  logic                         d_use_rs1,
  input  logic                         d_use_rs2,
  input  logic                         redirect,
  input  logic                         stall_ext,
  output logic [NUM_STAGES-1:0]        stage_valid,
  output logic [NUM_STAGES*CTRL_W-1:0] stage_ctrl,
  output logic [NUM_STAGES-1:0]        stage_regwr,
  output logic                         load_use_stall,
  output logic                         killF,
  output logic [FWD_W-1:0]             fwd_a,
  output logic [FWD_W-1:0]             fwd_b,
  output logic [CNT_W-1:0]             cnt_retired,
  output logic [CNT_W-1:0]             cnt_bubble,
  output logic [CNT_W-1:0]             cnt_kill
);

  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] regwr_q;
  logic [NUM_STAGES-1:0] memrd_q;
  logic [CTRL_W-1:0]     ctrl_q [NUM_STAGES];
  logic [REG_AW-1:0]     rd_q   [NUM_STAGES];

  logic                  s0_valid_d;
  logic                  s0_regwr_d;
  logic                  s0_memrd_d;
  logic [CTRL_W-1:0]     s0_ctrl_d;
  logic [REG_AW-1:0]     s0_rd_d;

  logic hit_rs1, hit_rs2;

  // Load-use hazard against the load currently in stage 0
  always_comb begin
    hit_rs1 = d_use_rs1 && (d_rs1 == rd_q[0]);
    hit_rs2 = d_use_rs2 && (d_rs2 == rd_q[0]);
    load_use_stall = d_valid && valid_q[0] && memrd_q[0] && regwr_q[0]
                     && (rd_q[0] != '0) && (hit_rs1 || hit_rs2);
    killF = d_valid && redirect && !load_use_stall && !stall_ext;
  end

  // Stage-0 entry: ID bundle or a bubble
  always_comb begin
    s0_valid_d = 1'b0;
    s0_regwr_d = 1'b0;
    s0_memrd_d = 1'b0;
    s0_ctrl_d  = '0;
    s0_rd_d    = '0;
    if (d_valid && !load_use_stall) begin
      s0_valid_d = 1'b1;
      s0_regwr_d = d_regwr;
      s0_memrd_d = d_memrd;
      s0_ctrl_d  = d_ctrl;
      s0_rd_d    = d_rd;
    end
  end

  // Stage registers: shift on advance, hold while frozen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      regwr_q <= '0;
      memrd_q <= '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        ctrl_q[i] <= '0;
        rd_q[i]   <= '0;
      end
    end else if (!stall_ext) begin
      valid_q[0] <= s0_valid_d;
      regwr_q[0] <= s0_regwr_d;
      memrd_q[0] <= s0_memrd_d;
      ctrl_q[0]  <= s0_ctrl_d;
      rd_q[0]    <= s0_rd_d;
      for (int i = 1; i < NUM_STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
        regwr_q[i] <= regwr_q[i-1];
        memrd_q[i] <= memrd_q[i-1];
        ctrl_q[i]  <= ctrl_q[i-1];
        rd_q[i]    <= rd_q[i-1];
      end
    end
  end

  assign stage_valid = valid_q;
  assign stage_regwr = valid_q & regwr_q;

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_ctrl
    assign stage_ctrl[g*CTRL_W +: CTRL_W] = valid_q[g] ? ctrl_q[g] : '0;
  end

  // Forwarding select: scan oldest to youngest so the youngest wins
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (valid_q[i] && regwr_q[i]) begin
        if (d_use_rs1 && d_rs1 != '0 && rd_q[i] == d_rs1)
          fwd_a = FWD_W'(i + 1);
        if (d_use_rs2 && d_rs2 != '0 && rd_q[i] == d_rs2)
          fwd_b = FWD_W'(i + 1);
      end
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] ret_q, bub_q, kil_q;

  // Saturating event counters, frozen with the pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ret_q <= '0;
      bub_q <= '0;
      kil_q <= '0;
    end else if (!stall_ext) begin
      if (valid_q[NUM_STAGES-1] && !(&ret_q))
        ret_q <= ret_q + 1'b1;
      if (load_use_stall && !(&bub_q))
        bub_q <= bub_q + 1'b1;
      if (killF && !(&kil_q))
        kil_q <= kil_q + 1'b1;
    end
  end

  assign cnt_retired = ret_q;
  assign cnt_bubble  = bub_q;
  assign cnt_kill    = kil_q;
`else
  assign cnt_retired = '0;
  assign cnt_bubble  = '0;
  assign cnt_kill    = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_sequencer.sv
// Scoreboard bench for ctrl_pipe_sequencer (NUM_STAGES=3, CTRL_W=8,
// CNT_W=4); counter expectations follow PERF_CNT_EN.
module tb_ctrl_pipe_sequencer;

  localparam int N  = 3;
  localparam int CW = 8;
  localparam int AW = 3;
  localparam int FW = $clog2(N + 1);
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          d_valid, d_regwr, d_memrd;
  logic [CW-1:0] d_ctrl;
  logic [AW-1:0] d_rd, d_rs1, d_rs2;
  logic          d_use_rs1, d_use_rs2, redirect, stall_ext;
  logic [N-1:0]  stage_valid, stage_regwr;
  logic [N*CW-1:0] stage_ctrl;
  logic          load_use_stall, killF;
  logic [FW-1:0] fwd_a, fwd_b;
  logic [KW-1:0] cnt_retired, cnt_bubble, cnt_kill;

  ctrl_pipe_sequencer #(
    .NUM_STAGES(N), .CTRL_W(CW), .REG_AW(AW), .CNT_W(KW)
  ) dut (
    .clk(clk), .reset(reset),
    .d_valid(d_valid), .d_ctrl(d_ctrl),
    .d_regwr(d_regwr), .d_memrd(d_memrd),
    .d_rd(d_rd), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
    .redirect(redirect), .stall_ext(stall_ext),
    .stage_valid(stage_valid), .stage_ctrl(stage_ctrl),
    .stage_regwr(stage_regwr),
    .load_use_stall(load_use_stall), .killF(killF),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .cnt_retired(cnt_retired), .cnt_bubble(cnt_bubble),
    .cnt_kill(cnt_kill)
  );

  always #5 clk = ~clk;

  typedef enum int {
    S_VALID, S_CTRL0, S_CTRL1, S_CTRL2, S_REGWR, S_LUS, S_KILL,
    S_FWDA, S_FWDB, S_CRET, S_CBUB, S_CKILL
  } sel_e;

  typedef struct {
    int          cyc;
    sel_e        sel;
    logic [31:0] exp;
    string       nm;
  } item_t;

  item_t q[$];
  item_t it;
  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] act(sel_e s);
    case (s)
      S_VALID: return 32'(stage_valid);
      S_CTRL0: return 32'(stage_ctrl[0*CW +: CW]);
      S_CTRL1: return 32'(stage_ctrl[1*CW +: CW]);
      S_CTRL2: return 32'(stage_ctrl[2*CW +: CW]);
      S_REGWR: return 32'(stage_regwr);
      S_LUS:   return 32'(load_use_stall);
      S_KILL:  return 32'(killF);
      S_FWDA:  return 32'(fwd_a);
      S_FWDB:  return 32'(fwd_b);
      S_CRET:  return 32'(cnt_retired);
      S_CBUB:  return 32'(cnt_bubble);
      default: return 32'(cnt_kill);
    endcase
  endfunction

  function automatic logic [31:0] cexp(logic [31:0] v);
`ifdef PERF_CNT_EN
    return v;
`else
    return 32'(v & 32'h0);
`endif
  endfunction

  // Monitor: pop every expectation due this cycle, away from the edge
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      it = q.pop_front();
      n_chk++;
      if (it.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: missed check cycle %0d (now %0d)",
                 it.nm, it.cyc, cyc);
      end else if (act(it.sel) !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h (cycle %0d)",
                 it.nm, act(it.sel), it.exp, cyc);
      end
    end
  end

  task automatic chk(sel_e s, logic [31:0] e, string nm);
    item_t x;
    x.cyc = cyc; x.sel = s; x.exp = e; x.nm = nm;
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    d_valid = 0; d_ctrl = '0; d_regwr = 0; d_memrd = 0;
    d_rd = '0; d_rs1 = '0; d_rs2 = '0;
    d_use_rs1 = 0; d_use_rs2 = 0; redirect = 0;
  endtask

  task automatic issue(logic [7:0] c, logic rw, logic mr, logic [2:0] rd,
                       logic [2:0] r1, logic u1, logic [2:0] r2, logic u2);
    d_valid = 1; d_ctrl = c; d_regwr = rw; d_memrd = mr; d_rd = rd;
    d_rs1 = r1; d_use_rs1 = u1; d_rs2 = r2; d_use_rs2 = u2;
    redirect = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle();
    step();
    reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; stall_ext = 0;
    idle();
    step(); step();
    reset = 0;
    chk(S_VALID, 0, "rst_valid");
    chk(S_CTRL0, 0, "rst_ctrl0");
    chk(S_REGWR, 0, "rst_regwr");
    chk(S_CRET, 0, "rst_cret");
    chk(S_CBUB, 0, "rst_cbub");
    chk(S_CKILL, 0, "rst_ckill");
    step();

    // 1: in-order flow
    issue(8'hA1, 1, 0, 3'd1, 0, 0, 0, 0); step();
    issue(8'hA2, 0, 0, 0, 0, 0, 0, 0);
    chk(S_CTRL0, 32'hA1, "t1_s0_a1");
    chk(S_VALID, 3'b001, "t1_v1");
    step();
    issue(8'hA3, 0, 0, 0, 0, 0, 0, 0);
    chk(S_CTRL1, 32'hA1, "t1_s1_a1");
    chk(S_CTRL0, 32'hA2, "t1_s0_a2");
    step();
    idle();
    chk(S_CTRL2, 32'hA1, "t1_s2_a1");
    chk(S_VALID, 3'b111, "t1_v111");
    chk(S_REGWR, 3'b100, "t1_regwr");
    step();

    // 2: load-use interlock
    do_reset();
    issue(8'h10, 1, 1, 3'd3, 0, 0, 0, 0); step();
    issue(8'h20, 1, 0, 3'd4, 3'd3, 1, 3'd6, 1);
    chk(S_LUS, 1, "t2_lus1");
    chk(S_KILL, 0, "t2_kill0");
    step();
    chk(S_LUS, 0, "t2_lus0");
    chk(S_VALID, 3'b010, "t2_bubble");
    chk(S_FWDA, 2, "t2_fwda");
    chk(S_FWDB, 0, "t2_fwdb");
    step();
    idle();
    chk(S_VALID, 3'b101, "t2_v101");
    chk(S_CTRL0, 32'h20, "t2_s0_add");
    chk(S_CBUB, cexp(1), "t2_cbub");
    step();

    // 3: youngest-wins forwarding, and R0 never forwards
    do_reset();
    issue(8'h31, 1, 0, 3'd2, 0, 0, 0, 0); step();
    issue(8'h32, 1, 0, 3'd2, 0, 0, 0, 0); step();
    issue(8'h33, 0, 0, 0, 3'd5, 1, 3'd2, 1);
    chk(S_FWDB, 1, "t3_fwdb_young");
    chk(S_FWDA, 0, "t3_fwda_none");
    chk(S_LUS, 0, "t3_lus");
    step();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(8'h34, 1, 1, 3'd0, 0, 0, 0, 0); step();
    end
    issue(8'h35, 1, 0, 3'd1, 3'd0, 1, 3'd0, 1);
    chk(S_VALID, 3'b111, "t3_v111");
    chk(S_FWDA, 0, "t3_r0_fwda");
    chk(S_FWDB, 0, "t3_r0_fwdb");
    chk(S_LUS, 0, "t3_r0_lus");
    step();

    // 4: redirect under freeze, then release
    do_reset();
    issue(8'h41, 0, 0, 0, 0, 0, 0, 0); step();
    issue(8'h42, 0, 0, 0, 0, 0, 0, 0); step();
    issue(8'h43, 0, 0, 0, 0, 0, 0, 0);
    redirect = 1; stall_ext = 1;
    chk(S_KILL, 0, "t4_kill_frz1");
    chk(S_VALID, 3'b011, "t4_v_frz1");
    step();
    chk(S_KILL, 0, "t4_kill_frz2");
    chk(S_VALID, 3'b011, "t4_v_frz2");
    chk(S_CTRL0, 32'h42, "t4_s0_frz");
    chk(S_CTRL1, 32'h41, "t4_s1_frz");
    step();
    stall_ext = 0;
    chk(S_KILL, 1, "t4_kill_rel");
    step();
    issue(8'h44, 0, 0, 0, 0, 0, 0, 0);
    chk(S_KILL, 0, "t4_kill_off");
    chk(S_CTRL0, 32'h43, "t4_s0_adv");
    chk(S_VALID, 3'b111, "t4_v111");
    chk(S_CKILL, cexp(1), "t4_ckill");
    chk(S_CRET, 0, "t4_cret0");
    step();
    issue(8'h45, 0, 0, 0, 0, 0, 0, 0);
    chk(S_CRET, cexp(1), "t4_cret1");
    chk(S_VALID, 3'b111, "t5_pre_v");
    step();

    // 5: asynchronous reset mid-stream
    reset = 1;
    idle();
    chk(S_VALID, 0, "t5_valid");
    chk(S_CTRL0, 0, "t5_ctrl0");
    chk(S_CTRL1, 0, "t5_ctrl1");
    chk(S_CTRL2, 0, "t5_ctrl2");
    chk(S_REGWR, 0, "t5_regwr");
    chk(S_CRET, 0, "t5_cret");
    chk(S_CKILL, 0, "t5_ckill");
    step();
    reset = 0;
    step();

    // 6: retirement counter saturation
    do_reset();
    for (int i = 0; i < 26; i++) begin
      issue(8'(8'h60 + i), 0, 0, 0, 0, 0, 0, 0);
      if (i == 10) chk(S_CRET, cexp(7), "t6_cret7");
      step();
    end
    idle();
    chk(S_CRET, cexp(32'hF), "t6_cret_sat");
    step(); step();

    if (q.size() != 0) begin
      n_fail += q.size();
      n_chk  += q.size();
      $display("FAIL scoreboard: %0d checks never reached", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
